// File: rtl/clk_div_bank.sv
// clk_div_bank: multi-channel programmable divider producing slow clocks/strobes and terminal ticks,
// with shadowed divisor reload applied only at a wrap or global SYNC.
module clk_div_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 24,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = {WIDTH{1'b1}}
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic [CHANNELS-1:0] EN,
  input  logic                SYNC,
  input  logic                LOAD_VALID,
  output logic                LOAD_READY,
  input  logic [3:0]          LOAD_CH,
  input  logic [WIDTH-1:0]    LOAD_DIV,
  input  logic                LOAD_MODE,
  output logic                LOAD_ERR,
  output logic [CHANNELS-1:0] SLOW,
  output logic [CHANNELS-1:0] TICK
);
  logic [WIDTH-1:0] cnt [CHANNELS];
  logic [WIDTH-1:0] div_act [CHANNELS];
  logic [WIDTH-1:0] div_sh [CHANNELS];
  logic [WIDTH-1:0] nxt_div [CHANNELS];
  logic [CHANNELS-1:0] mode_act, mode_sh, pending, nxt_mode, reload;
  logic [15:0] pend_x;
  logic ch_ok, accept;
  always_comb begin
    pend_x = '0;
    pend_x[CHANNELS-1:0] = pending;
    ch_ok = int'(LOAD_CH) < CHANNELS;
    LOAD_READY = ch_ok ? ~pend_x[LOAD_CH] : 1'b1;
    accept = LOAD_VALID & LOAD_READY;
    for (int i = 0; i < CHANNELS; i++) begin
      nxt_div[i] = pending[i] ? div_sh[i] : div_act[i];
      nxt_mode[i] = pending[i] ? mode_sh[i] : mode_act[i];
      reload[i] = SYNC | (EN[i] & (cnt[i] == '0));
    end
  end
  // The shadow is written after the reload so an accept on a wrap edge stays pending for the next wrap.
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= DEFAULT_DIV;
        div_act[i] <= DEFAULT_DIV;
        div_sh[i] <= DEFAULT_DIV;
      end
      mode_act <= '0;
      mode_sh <= '0;
      pending <= '0;
      SLOW <= '0;
      TICK <= '0;
      LOAD_ERR <= 1'b0;
    end else begin
      LOAD_ERR <= accept & ~ch_ok;
      for (int i = 0; i < CHANNELS; i++) begin
        if (reload[i]) begin
          cnt[i] <= nxt_div[i];
          div_act[i] <= nxt_div[i];
          mode_act[i] <= nxt_mode[i];
          pending[i] <= 1'b0;
          TICK[i] <= ~SYNC;
          SLOW[i] <= ~SYNC & (nxt_mode[i] | ~SLOW[i]);
        end else begin
          if (EN[i]) cnt[i] <= cnt[i] - 1'b1;
          TICK[i] <= 1'b0;
          if (mode_act[i]) SLOW[i] <= 1'b0;
        end
        if (accept && ch_ok && LOAD_CH == 4'(i)) begin
          div_sh[i] <= LOAD_DIV;
          mode_sh[i] <= LOAD_MODE;
          pending[i] <= 1'b1;
        end
      end
    end
endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Parametrised multi-channel clock-enable and slow-clock generator.
- Each channel divides CLOCK by a runtime-programmable divisor.
- Each channel outputs either a 50% square wave (toggle mode) or a one-cycle strobe (pulse mode), plus a per-channel terminal-count tick.
- Serves as the single source of slow enables for display scanning, debouncing and LED blink logic.
- Adds glitch-free divisor reload, a load handshake and global phase sync.

Parameters:
- CHANNELS, 4, number of independent divider channels (1..16).
- WIDTH, 24, counter and divisor width in bits.
- DEFAULT_DIV, 2**WIDTH-1, divisor loaded into every channel at reset.

Ports:
- CLOCK  input  1  system clock, all logic on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- EN  input  CHANNELS  per-channel count enable.
- SYNC  input  1  single-cycle global phase-alignment restart.
- LOAD_VALID  input  1  divisor/mode load request.
- LOAD_READY  output  1  load can be accepted this cycle.
- LOAD_CH  input  4  target channel index.
- LOAD_DIV  input  WIDTH  new divisor D; channel period is D+1 cycles.
- LOAD_MODE  input  1  0 = toggle, 1 = pulse.
- LOAD_ERR  output  1  one-cycle flag: an accepted load targeted a nonexistent channel.
- SLOW  output  CHANNELS  per-channel slow clock or strobe.
- TICK  output  CHANNELS  per-channel terminal-count pulse.

Behaviour:
- State per channel:
  - cnt[WIDTH], div_act, mode_act.
  - Shadow div_sh and mode_sh.
  - pending flag.
- All outputs are registered.
- Reset, asynchronous:
  - cnt = div_act = DEFAULT_DIV; mode_act = 0; pending = 0.
  - SLOW = 0, TICK = 0, LOAD_ERR = 0.
  - LOAD_READY reflects the reset state combinationally.
- Counting, per edge with EN[i] = 1 and no SYNC:
  - If cnt != 0: cnt decrements; TICK <= 0; in pulse mode SLOW <= 0; in toggle mode SLOW holds.
  - If cnt == 0 (wrap): TICK <= 1.
  - At wrap, if pending: div_act <= div_sh, mode_act <= mode_sh, pending <= 0, cnt <= div_sh.
  - At wrap, if not pending: cnt <= div_act.
  - At wrap, SLOW update uses the post-wrap mode: toggle gives SLOW <= ~SLOW; pulse gives SLOW <= 1.
- Resulting periods with EN held high:
  - Wrap every D+1 cycles.
  - Toggle-mode SLOW period is 2(D+1).
  - Pulse-mode SLOW is high 1 of every D+1 cycles.
  - Default reset config reproduces the legacy 2^24-cycle toggle.
- D = 0:
  - Toggle mode gives SLOW = CLOCK/2 and TICK constantly 1.
  - Pulse mode gives SLOW constantly 1.
- EN[i] = 0: cnt, pending and toggle-mode SLOW hold; TICK <= 0; pulse-mode SLOW <= 0.
- Load handshake:
  - LOAD_READY = ~pending[LOAD_CH] when LOAD_CH < CHANNELS, else 1. It is combinational from LOAD_CH and pending only.
  - Accept occurs when LOAD_VALID & LOAD_READY.
  - Valid channel: div_sh <= LOAD_DIV, mode_sh <= LOAD_MODE, pending <= 1.
  - Out-of-range channel: data dropped, LOAD_ERR <= 1 for one cycle.
  - Only one shadow per channel; a second load to the same channel stalls until the wrap.
- Accept and wrap on the same channel in the same cycle: the wrap uses the pre-existing state and the new value becomes pending. The new value applies at the next wrap, never mid-period.
- SYNC (dominates wrap and EN), for all channels on the same edge:
  - If pending, apply the shadow.
  - cnt <= resulting div_act; pending <= 0.
  - SLOW <= 0, TICK <= 0.
- A load accepted in the SYNC cycle is not applied by that SYNC; it becomes pending.
- After SYNC, all enabled channels with equal D tick on the same cycle: D+1 edges later.
- RESET mid-operation: all pending loads are discarded immediately.

Test Plan:
- Reset release, EN = 4'hF, LOAD idle, run 2^25+4 cycles -> SLOW[0] first rises at edge 2^24 and falls at 2^25; TICK[0] high exactly 2 cycles total.
- Load ch1 D = 4 mode 0, then SYNC -> SLOW[1] period 10 cycles, 50% duty; TICK[1] every 5th cycle, first at edge 5 after SYNC.
- Load ch2 D = 2 mode 1, then SYNC; then load D = 6 at the cycle ch2 wraps -> old period 3 continues one more period; the next pulses are spaced 7; LOAD_READY low for ch2 until that wrap.
- Second load to ch2 while pending -> LOAD_READY = 0 and the request is held; it is accepted on the cycle after the wrap.
- LOAD_CH = 9 with CHANNELS = 4 -> accepted; LOAD_ERR one cycle; no channel state changes.
- Channels 0..3 all D = 3, EN toggled unevenly to skew phases, then SYNC -> all TICK assert together 4 cycles later; EN[3] = 0 freezes cnt[3] and SLOW[3]; resuming continues from the held count.
